// File: rtl/memory_arbiter.sv
// Two-port (fetch/data) arbiter in front of a single-ported memory. Ties are broken
// round-robin, reads have a fixed latency, and writes are handshaked with a timeout.
module memory_arbiter #(
  parameter int READ_LATENCY  = 2,
  parameter int WRITE_TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_ack,
  output logic [31:0] if_rdata,
  input  logic        d_req,
  input  logic [31:0] d_addr,
  input  logic [1:0]  d_write_mode,
  input  logic [1:0]  d_size,
  input  logic [31:0] d_wdata,
  output logic        d_ack,
  output logic [31:0] d_rdata,
  output logic        err,
  output logic [31:0] mem_address,
  output logic [1:0]  mem_write_mode,
  output logic [7:0]  mem_write_byte,
  output logic [15:0] mem_write_half_word,
  output logic [31:0] mem_write_word,
  input  logic        mem_done,
  input  logic [7:0]  mem_byte,
  input  logic [15:0] mem_half_word,
  input  logic [31:0] mem_word
);
  localparam int CNT_MAX = (READ_LATENCY > WRITE_TIMEOUT) ? READ_LATENCY : WRITE_TIMEOUT;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] RD_LAST = CNT_W'(READ_LATENCY - 1);
  localparam logic [CNT_W-1:0] WR_LAST = CNT_W'(WRITE_TIMEOUT - 1);

  typedef enum logic [2:0] {IDLE, READ_WAIT, WRITE_WAIT, RELEASE, RESP} state_t;

  state_t           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             last_data_q;
  logic             port_data_q;
  logic [1:0]       size_q;
  logic [31:0]      addr_q;
  logic [31:0]      wdata_q;
  logic [31:0]      rdata_q;
  logic [1:0]       mem_mode_q;
  logic             if_ack_q;
  logic             d_ack_q;
  logic             err_q;
  logic             grant_data_d;
  logic [31:0]      rdata_d;

  // On a tie the port that did not win last time is served.
  always_comb begin
    grant_data_d = d_req && (!if_req || !last_data_q);
  end

  always_comb begin
    rdata_d = mem_word;
    if (port_data_q) begin
      case (size_q)
        2'd1:    rdata_d = {24'b0, mem_byte};
        2'd2:    rdata_d = {16'b0, mem_half_word};
        default: rdata_d = mem_word;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      last_data_q <= 1'b1;
      port_data_q <= 1'b0;
      size_q      <= 2'd0;
      addr_q      <= '0;
      wdata_q     <= '0;
      rdata_q     <= '0;
      mem_mode_q  <= 2'd0;
      if_ack_q    <= 1'b0;
      d_ack_q     <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      if_ack_q <= 1'b0;
      d_ack_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          // A memory still finishing an abandoned write holds off new grants.
          if (!mem_done && (if_req || d_req)) begin
            port_data_q <= grant_data_d;
            last_data_q <= grant_data_d;
            cnt_q       <= '0;
            if (grant_data_d) begin
              addr_q  <= d_addr;
              size_q  <= d_size;
              wdata_q <= d_wdata;
              if (d_write_mode != 2'd0) begin
                mem_mode_q <= d_write_mode;
                state_q    <= WRITE_WAIT;
              end else begin
                state_q <= READ_WAIT;
              end
            end else begin
              addr_q  <= if_addr;
              size_q  <= 2'd3;
              state_q <= READ_WAIT;
            end
          end
        end
        READ_WAIT: begin
          if (cnt_q == RD_LAST) begin
            rdata_q  <= rdata_d;
            if_ack_q <= !port_data_q;
            d_ack_q  <= port_data_q;
            state_q  <= RESP;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        WRITE_WAIT: begin
          if (mem_done) begin
            mem_mode_q <= 2'd0;
            state_q    <= RELEASE;
          end else if (cnt_q == WR_LAST) begin
            err_q      <= 1'b1;
            mem_mode_q <= 2'd0;
            state_q    <= RELEASE;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        RELEASE: begin
          if (!mem_done) begin
            rdata_q <= '0;
            d_ack_q <= 1'b1;
            state_q <= RESP;
          end
        end
        RESP: begin
          addr_q  <= '0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign if_ack              = if_ack_q;
  assign d_ack               = d_ack_q;
  assign if_rdata            = rdata_q;
  assign d_rdata             = rdata_q;
  assign err                 = err_q;
  assign mem_address         = addr_q;
  assign mem_write_mode      = mem_mode_q;
  assign mem_write_byte      = wdata_q[7:0];
  assign mem_write_half_word = wdata_q[15:0];
  assign mem_write_word      = wdata_q;
endmodule
